// File: rtl/br_resolve.sv
// Branch-resolution stage: registers each resolved branch, flags mispredicts,
// and drives the frontend redirect, a younger-state flush, BPU training and ROB writeback.
module br_resolve #(
    parameter int ROB_W = 6,
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             valid_i,
    output logic             ready_o,
    input  logic [31:0]      pc_i,
    input  logic [31:0]      target_i,
    input  logic             taken_i,
    input  logic             pred_taken_i,
    input  logic [31:0]      pred_target_i,
    input  logic [ROB_W-1:0] rob_id_i,
    input  logic             flush_i,
    output logic             redirect_valid_o,
    output logic [31:0]      redirect_pc_o,
    input  logic             redirect_ready_i,
    output logic             flush_o,
    output logic             bpu_upd_valid_o,
    output logic [31:0]      bpu_upd_pc_o,
    output logic             bpu_upd_taken_o,
    output logic [31:0]      bpu_upd_target_o,
    output logic             wb_valid_o,
    output logic [ROB_W-1:0] wb_rob_id_o,
    output logic             wb_mispred_o,
    output logic [CNT_W-1:0] mispred_cnt_o,
    output logic [CNT_W-1:0] branch_cnt_o
);

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_REDIR = 1'b1
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic               w_accept;
    logic               w_mispred;
    logic [31:0]        w_next_pc;
    logic               r_strobe;
    logic               r_flush;
    logic [31:0]        r_redirect_pc;
    logic [31:0]        r_bpu_pc;
    logic               r_bpu_taken;
    logic [31:0]        r_bpu_target;
    logic [ROB_W-1:0]   r_rob_id;
    logic               r_mispred;
    logic [CNT_W-1:0]   r_mispred_cnt;
    logic [CNT_W-1:0]   r_branch_cnt;

    // Handshake: a branch transfers on any cycle where valid_i && ready_o; the
    // producer holds its data until then, and ready_o never depends on valid_i.
    assign ready_o   = (r_state == S_IDLE) && !flush_i;
    assign w_accept  = valid_i && ready_o;
    assign w_next_pc = taken_i ? target_i : pc_i + 32'd4;
    assign w_mispred = (taken_i != pred_taken_i) || (taken_i && (target_i != pred_target_i));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        if (flush_i) begin
            w_state_nxt = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE:  if (w_accept && w_mispred) w_state_nxt = S_REDIR;
                S_REDIR: if (redirect_ready_i)      w_state_nxt = S_IDLE;
                default: w_state_nxt = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_strobe      <= 1'b0;
            r_flush       <= 1'b0;
            r_redirect_pc <= '0;
            r_bpu_pc      <= '0;
            r_bpu_taken   <= 1'b0;
            r_bpu_target  <= '0;
            r_rob_id      <= '0;
            r_mispred     <= 1'b0;
            r_mispred_cnt <= '0;
            r_branch_cnt  <= '0;
        end else begin
            r_strobe <= w_accept;
            r_flush  <= w_accept && w_mispred;
            if (w_accept) begin
                r_bpu_pc     <= pc_i;
                r_bpu_taken  <= taken_i;
                r_bpu_target <= target_i;
                r_rob_id     <= rob_id_i;
                r_mispred    <= w_mispred;
                r_branch_cnt <= r_branch_cnt + 1'b1;
                if (w_mispred) begin
                    r_redirect_pc <= w_next_pc;
                    r_mispred_cnt <= r_mispred_cnt + 1'b1;
                end
            end
        end
    end

    // A commit flush in the cycle after a mispredicting accept overrides that
    // branch's own kill and redirect; its writeback and training still go out.
    assign flush_o          = r_flush && !flush_i;
    assign redirect_valid_o = (r_state == S_REDIR) && !flush_i;
    assign redirect_pc_o    = r_redirect_pc;
    assign bpu_upd_valid_o  = r_strobe;
    assign bpu_upd_pc_o     = r_bpu_pc;
    assign bpu_upd_taken_o  = r_bpu_taken;
    assign bpu_upd_target_o = r_bpu_target;
    assign wb_valid_o       = r_strobe;
    assign wb_rob_id_o      = r_rob_id;
    assign wb_mispred_o     = r_mispred;
    assign mispred_cnt_o    = r_mispred_cnt;
    assign branch_cnt_o     = r_branch_cnt;

endmodule

// File: tb/tb_br_resolve.sv
// Bench for br_resolve: directed steps from the test plan, then random traffic,
// all checked cycle by cycle against a transaction-level reference model.
module tb_br_resolve;
    localparam int ROB_W = 6;
    localparam int CNT_W = 32;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             valid_i;
    logic             ready_o;
    logic [31:0]      pc_i;
    logic [31:0]      target_i;
    logic             taken_i;
    logic             pred_taken_i;
    logic [31:0]      pred_target_i;
    logic [ROB_W-1:0] rob_id_i;
    logic             flush_i;
    logic             redirect_valid_o;
    logic [31:0]      redirect_pc_o;
    logic             redirect_ready_i;
    logic             flush_o;
    logic             bpu_upd_valid_o;
    logic [31:0]      bpu_upd_pc_o;
    logic             bpu_upd_taken_o;
    logic [31:0]      bpu_upd_target_o;
    logic             wb_valid_o;
    logic [ROB_W-1:0] wb_rob_id_o;
    logic             wb_mispred_o;
    logic [CNT_W-1:0] mispred_cnt_o;
    logic [CNT_W-1:0] branch_cnt_o;

    always #5 clk = ~clk;

    br_resolve #(.ROB_W(ROB_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .valid_i(valid_i), .ready_o(ready_o),
        .pc_i(pc_i), .target_i(target_i), .taken_i(taken_i),
        .pred_taken_i(pred_taken_i), .pred_target_i(pred_target_i),
        .rob_id_i(rob_id_i), .flush_i(flush_i),
        .redirect_valid_o(redirect_valid_o), .redirect_pc_o(redirect_pc_o),
        .redirect_ready_i(redirect_ready_i), .flush_o(flush_o),
        .bpu_upd_valid_o(bpu_upd_valid_o), .bpu_upd_pc_o(bpu_upd_pc_o),
        .bpu_upd_taken_o(bpu_upd_taken_o), .bpu_upd_target_o(bpu_upd_target_o),
        .wb_valid_o(wb_valid_o), .wb_rob_id_o(wb_rob_id_o), .wb_mispred_o(wb_mispred_o),
        .mispred_cnt_o(mispred_cnt_o), .branch_cnt_o(branch_cnt_o)
    );

    int n_checks = 0;
    int n_fails  = 0;

    // Reference model: one outstanding redirect, one pending completion record.
    bit               m_redir;
    logic [31:0]      m_rpc;
    bit               m_pend;
    logic [31:0]      m_pc;
    bit               m_taken;
    logic [31:0]      m_target;
    logic [ROB_W-1:0] m_rob;
    bit               m_mis;
    logic [31:0]      m_mcnt;
    logic [31:0]      m_bcnt;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_redir = 0; m_rpc = '0; m_pend = 0; m_pc = '0; m_taken = 0;
        m_target = '0; m_rob = '0; m_mis = 0; m_mcnt = '0; m_bcnt = '0;
    endtask

    // Drive one cycle's inputs, check every output, advance the model, clock.
    task automatic cyc(input bit v, input logic [31:0] pc, input logic [31:0] tgt,
                       input bit tk, input bit ptk, input logic [31:0] ptgt,
                       input logic [ROB_W-1:0] rob, input bit fl, input bit rr);
        bit          e_ready;
        bit          acc;
        bit          mis;
        logic [31:0] npc;
        valid_i = v; pc_i = pc; target_i = tgt; taken_i = tk; pred_taken_i = ptk;
        pred_target_i = ptgt; rob_id_i = rob; flush_i = fl; redirect_ready_i = rr;
        #1;
        e_ready = !m_redir && !fl;
        check("ready_o", {31'd0, ready_o}, {31'd0, e_ready});
        check("wb_valid", {31'd0, wb_valid_o}, {31'd0, m_pend});
        check("bpu_valid", {31'd0, bpu_upd_valid_o}, {31'd0, m_pend});
        check("flush_o", {31'd0, flush_o}, {31'd0, m_pend && m_mis && !fl});
        check("redir_valid", {31'd0, redirect_valid_o}, {31'd0, m_redir && !fl});
        check("redir_pc", redirect_pc_o, m_rpc);
        check("wb_rob", {26'd0, wb_rob_id_o}, {26'd0, m_rob});
        check("wb_mispred", {31'd0, wb_mispred_o}, {31'd0, m_mis});
        check("bpu_pc", bpu_upd_pc_o, m_pc);
        check("bpu_taken", {31'd0, bpu_upd_taken_o}, {31'd0, m_taken});
        check("bpu_target", bpu_upd_target_o, m_target);
        check("mispred_cnt", mispred_cnt_o, m_mcnt);
        check("branch_cnt", branch_cnt_o, m_bcnt);
        acc = v && e_ready;
        if (fl) m_redir = 0;
        else if (m_redir && rr) m_redir = 0;
        m_pend = acc;
        if (acc) begin
            npc = tk ? tgt : pc + 32'd4;
            mis = (tk != ptk) || (tk && (tgt != ptgt));
            m_pc = pc; m_taken = tk; m_target = tgt; m_rob = rob; m_mis = mis;
            m_bcnt = m_bcnt + 1;
            if (mis) begin
                m_mcnt = m_mcnt + 1;
                m_redir = 1;
                m_rpc = npc;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n, input bit rr, input bit fl);
        for (int i = 0; i < n; i++) cyc(0, 32'h0, 32'h0, 0, 0, 32'h0, '0, fl, rr);
    endtask

    initial begin
        rst_n = 1'b0; valid_i = 0; pc_i = '0; target_i = '0; taken_i = 0;
        pred_taken_i = 0; pred_target_i = '0; rob_id_i = '0; flush_i = 0;
        redirect_ready_i = 0;
        model_reset();
        #12;
        check("rst_redir_valid", {31'd0, redirect_valid_o}, 32'd0);
        check("rst_redir_pc", redirect_pc_o, 32'd0);
        check("rst_wb_valid", {31'd0, wb_valid_o}, 32'd0);
        check("rst_flush_o", {31'd0, flush_o}, 32'd0);
        check("rst_branch_cnt", branch_cnt_o, 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // 1: correct not-taken, then correct taken
        cyc(1, 32'h1C000000, 32'h0, 0, 0, 32'h0, 6'd1, 0, 0);
        cyc(1, 32'h1C000000, 32'h1C000100, 1, 1, 32'h1C000100, 6'd2, 0, 0);
        idle(1, 0, 0);
        check("t1_branch_cnt", branch_cnt_o, 32'd2);

        // 2: direction mispredict, redirect_ready low three cycles then high
        cyc(1, 32'h1C000010, 32'h0, 0, 1, 32'h0, 6'd3, 0, 0);
        check("t2_redir_pc", redirect_pc_o, 32'h1C000014);
        idle(3, 0, 0);
        idle(1, 1, 0);
        idle(1, 0, 0);
        check("t2_mispred_cnt", mispred_cnt_o, 32'd1);

        // 3: target mispredict with immediate redirect acceptance
        cyc(1, 32'h1C000020, 32'h2000, 1, 1, 32'h3000, 6'd4, 0, 1);
        check("t3_redir_pc", redirect_pc_o, 32'h2000);
        cyc(1, 32'h1C000030, 32'h0, 0, 0, 32'h0, 6'd5, 0, 1);
        cyc(1, 32'h1C000030, 32'h0, 0, 0, 32'h0, 6'd5, 0, 1);
        idle(1, 0, 0);

        // 4: fall-through address wraps
        cyc(1, 32'hFFFFFFFC, 32'h0, 0, 1, 32'h0, 6'd6, 0, 0);
        check("t4_redir_pc", redirect_pc_o, 32'h0);
        idle(2, 1, 0);

        // 5a: flush during REDIR, with a branch offered in the flush cycle
        cyc(1, 32'h1C000040, 32'h500, 1, 0, 32'h0, 6'd7, 0, 0);
        idle(1, 0, 0);
        cyc(1, 32'h1C000050, 32'h0, 0, 0, 32'h0, 6'd8, 1, 0);
        cyc(1, 32'h1C000060, 32'h0, 0, 0, 32'h0, 6'd9, 0, 0);
        // 5b: flush in the cycle after a mispredicting accept
        cyc(1, 32'h1C000070, 32'h0, 0, 1, 32'h0, 6'd10, 0, 0);
        idle(1, 0, 1);
        idle(2, 0, 0);

        // 6: asynchronous reset while a redirect is outstanding
        cyc(1, 32'h1C000080, 32'h900, 1, 1, 32'h800, 6'd11, 0, 0);
        valid_i = 0; redirect_ready_i = 0;
        #2;
        rst_n = 1'b0;
        #1;
        check("t6_redir_valid", {31'd0, redirect_valid_o}, 32'd0);
        check("t6_flush_o", {31'd0, flush_o}, 32'd0);
        check("t6_wb_valid", {31'd0, wb_valid_o}, 32'd0);
        check("t6_mispred_cnt", mispred_cnt_o, 32'd0);
        check("t6_branch_cnt", branch_cnt_o, 32'd0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            logic [31:0] pc, tgt, ptgt;
            bit tk, ptk;
            pc   = ($urandom_range(0, 15) == 0) ? 32'hFFFFFFFC : ($urandom() & 32'hFFFFFFFC);
            tgt  = $urandom() & 32'hFFFFFFFC;
            tk   = $urandom_range(0, 1) == 1;
            ptk  = ($urandom_range(0, 3) == 0) ? !tk : tk;
            ptgt = ($urandom_range(0, 3) == 0) ? ($urandom() & 32'hFFFFFFFC) : tgt;
            cyc($urandom_range(0, 9) < 7, pc, tgt, tk, ptk, ptgt,
                ROB_W'($urandom_range(0, 63)), $urandom_range(0, 19) == 0,
                $urandom_range(0, 1) == 1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end
endmodule
